// File: rtl/pin_entry_encoder_if.sv
// pin_entry_encoder_if
// Groups the keypad strobes, gate-controller status and the encoded-code
// outputs of pin_entry_encoder into one bundle.
//   master : drives keypad/gate-controller signals, observes the code outputs
//   slave  : the encoder side (pin_entry_encoder)
// Signals:
//   keyValid/keyDigit  digit strobe and BCD digit
//   keyEnter/keyClear  submit / discard strobes
//   gateState, wrongPinAlarm, blockAlarm  gate-controller status
//   pass, passValid    composed code and its one-cycle submission strobe
//   tryCount, lockout, digitCount  status outputs
interface pin_entry_encoder_if;
    logic       keyValid;
    logic [3:0] keyDigit;
    logic       keyEnter;
    logic       keyClear;
    logic       gateState;
    logic       wrongPinAlarm;
    logic       blockAlarm;
    logic [7:0] pass;
    logic       passValid;
    logic [1:0] tryCount;
    logic       lockout;
    logic [1:0] digitCount;

    modport master (
        output keyValid, keyDigit, keyEnter, keyClear,
        output gateState, wrongPinAlarm, blockAlarm,
        input  pass, passValid, tryCount, lockout, digitCount
    );

    modport slave (
        input  keyValid, keyDigit, keyEnter, keyClear,
        input  gateState, wrongPinAlarm, blockAlarm,
        output pass, passValid, tryCount, lockout, digitCount
    );
endinterface

// File: rtl/pin_entry_encoder.sv
// pin_entry_encoder
// Collects two BCD digits from a keypad into an 8-bit code, submits it to a
// gate controller on keyEnter, then waits for the gate to open (or times out).
// Tracks submissions since the last success and mirrors the wrong-pin alarm.
// Ports:
//   clk      single clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      pin_entry_encoder_if.slave: keypad strobes, gate status in;
//            pass/passValid/tryCount/lockout/digitCount out
module pin_entry_encoder #(
    parameter int unsigned RESP_TIMEOUT = 4,
    parameter int unsigned MAX_TRIES    = 3
) (
    input logic                clk,
    input logic                reset_n,
    pin_entry_encoder_if.slave bus
);
    localparam int unsigned TW = $clog2(RESP_TIMEOUT + 1);
    localparam logic [1:0]  TRY_LIMIT = 2'(MAX_TRIES);
    localparam logic [TW-1:0] WAIT_LAST = TW'(RESP_TIMEOUT - 1);

    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        ONE    = 6'b000010,
        TWO    = 6'b000100,
        SEND   = 6'b001000,
        WAIT   = 6'b010000,
        OPENED = 6'b100000
    } state_t;

    state_t        state, nextState;
    logic [TW-1:0] waitCount;
    logic [7:0]    passReg;
    logic          passValidReg;
    logic [1:0]    tryReg;
    logic          lockReg;
    logic [1:0]    digitCnt;

    logic digitOk, loadHigh, loadLow, clearPass, resetTries;

    always_comb begin
        nextState  = state;
        loadHigh   = 1'b0;
        loadLow    = 1'b0;
        clearPass  = 1'b0;
        resetTries = 1'b0;
        digitOk    = bus.keyValid && (bus.keyDigit <= 4'd9);
        unique case (state)
            IDLE: begin
                if (bus.keyClear) begin
                    clearPass = 1'b1;
                end else if (digitOk) begin
                    loadHigh  = 1'b1;
                    nextState = ONE;
                end
            end
            ONE: begin
                if (bus.keyClear) begin
                    clearPass = 1'b1;
                    nextState = IDLE;
                end else if (digitOk) begin
                    loadLow   = 1'b1;
                    nextState = TWO;
                end
            end
            TWO: begin
                if (bus.keyClear) begin
                    clearPass = 1'b1;
                    nextState = IDLE;
                end else if (bus.keyEnter && !bus.blockAlarm) begin
                    nextState = SEND;
                end
            end
            SEND: nextState = WAIT;
            WAIT: begin
                if (bus.gateState) begin
                    nextState = OPENED;
                end else if (waitCount == WAIT_LAST) begin
                    clearPass = 1'b1;
                    nextState = IDLE;
                end
            end
            OPENED: begin
                if (!bus.gateState) begin
                    clearPass  = 1'b1;
                    resetTries = 1'b1;
                    nextState  = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            passReg      <= '0;
            passValidReg <= 1'b0;
            tryReg       <= '0;
            lockReg      <= 1'b0;
            waitCount    <= '0;
        end else begin
            state <= nextState;
            if (clearPass) begin
                passReg <= '0;
            end else if (loadHigh) begin
                passReg <= {bus.keyDigit, 4'h0};
            end else if (loadLow) begin
                passReg[3:0] <= bus.keyDigit;
            end
            // passValid and the try increment are launched on entry to SEND so
            // both are visible during the single SEND cycle.
            passValidReg <= (nextState == SEND);
            // A falling lockout clears the count even if a submission is
            // being launched on the same edge.
            if (resetTries || (lockReg && !bus.wrongPinAlarm)) begin
                tryReg <= '0;
            end else if (nextState == SEND && tryReg < TRY_LIMIT) begin
                tryReg <= tryReg + 2'd1;
            end
            lockReg <= bus.wrongPinAlarm;
            // WAIT is only entered from SEND, so the counter restarts there.
            if (state == SEND) begin
                waitCount <= '0;
            end else if (state == WAIT) begin
                waitCount <= waitCount + TW'(1);
            end
        end
    end

    always_comb begin
        digitCnt = 2'd2;
        if (state == IDLE) begin
            digitCnt = 2'd0;
        end else if (state == ONE) begin
            digitCnt = 2'd1;
        end
    end

    assign bus.pass       = passReg;
    assign bus.passValid  = passValidReg;
    assign bus.tryCount   = tryReg;
    assign bus.lockout    = lockReg;
    assign bus.digitCount = digitCnt;
endmodule
